// File: rtl/arb_rr_pkt_mux.sv
// Packet-aware round-robin merge of WID valid/ready streams into one registered output stage.
// A source keeps the grant from its first beat through its in_lst beat.
module arb_rr_pkt_mux #(
  parameter int WID     = 4,
  parameter int DAT_WID = 32,
  localparam int SRC_WID = $clog2(WID)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WID-1:0]         in_vld,
  input  logic [WID-1:0]         in_lst,
  input  logic [WID*DAT_WID-1:0] in_dat,
  output logic [WID-1:0]         in_rdy,
  output logic                   out_vld,
  output logic                   out_lst,
  output logic [DAT_WID-1:0]     out_dat,
  output logic [SRC_WID-1:0]     out_src,
  input  logic                   out_rdy,
  output logic                   busy
);

  // Handshake: a beat moves on a channel in a cycle where valid && ready are both
  // high at the rising edge; valid/data/last must stay stable until that happens.

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [SRC_WID-1:0] owner_q, owner_d;
  logic [WID-1:0]     mask_q, mask_d;
  logic               out_vld_q, out_vld_d;
  logic               out_lst_q, out_lst_d;
  logic [DAT_WID-1:0] out_dat_q, out_dat_d;
  logic [SRC_WID-1:0] out_src_q, out_src_d;

  logic               ld;
  logic               xfer;
  logic [WID-1:0]     mreq;
  logic [SRC_WID-1:0] sel_all, sel_msk, sel, gnt;

  always_comb begin
    mreq    = in_vld & mask_q;
    sel_all = '0;
    sel_msk = '0;
    // Downward scan leaves the lowest set bit as the winner.
    for (int i = WID - 1; i >= 0; i--) begin
      if (in_vld[i]) sel_all = SRC_WID'(i);
      if (mreq[i])   sel_msk = SRC_WID'(i);
    end
    sel = (|mreq) ? sel_msk : sel_all;
  end

  always_comb begin
    ld     = !out_vld_q || out_rdy;
    gnt    = (state_q == ST_LOCK) ? owner_q : sel;
    in_rdy = '0;
    if ((state_q == ST_LOCK) || (|in_vld)) in_rdy[gnt] = ld;
    xfer   = ld && in_vld[gnt];
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    mask_d    = mask_q;
    out_vld_d = out_vld_q;
    out_lst_d = out_lst_q;
    out_dat_d = out_dat_q;
    out_src_d = out_src_q;
    if (xfer) begin
      out_vld_d = 1'b1;
      out_lst_d = in_lst[gnt];
      out_dat_d = in_dat[int'(gnt)*DAT_WID +: DAT_WID];
      out_src_d = gnt;
      if (in_lst[gnt]) begin
        state_d = ST_IDLE;
        // Only sources above the finishing one stay eligible; all-zero falls back to lsb-first.
        for (int i = 0; i < WID; i++) mask_d[i] = (i > int'(gnt));
      end else begin
        state_d = ST_LOCK;
        owner_d = gnt;
      end
    end else if (ld) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      mask_q    <= '1;
      out_vld_q <= 1'b0;
      out_lst_q <= 1'b0;
      out_dat_q <= '0;
      out_src_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      mask_q    <= mask_d;
      out_vld_q <= out_vld_d;
      out_lst_q <= out_lst_d;
      out_dat_q <= out_dat_d;
      out_src_q <= out_src_d;
    end
  end

  assign out_vld = out_vld_q;
  assign out_lst = out_lst_q;
  assign out_dat = out_dat_q;
  assign out_src = out_src_q;
  assign busy    = (state_q == ST_LOCK);

endmodule

// File: tb/tb_arb_rr_pkt_mux.sv
// Randomized bench for arb_rr_pkt_mux: circular-search round-robin reference model,
// per-cycle output/in_rdy checks and an in-order beat scoreboard.
module tb_arb_rr_pkt_mux;

  localparam int WID     = 4;
  localparam int DAT_WID = 32;
  localparam int SRC_WID = 2;
  localparam int W       = SRC_WID + 1 + DAT_WID;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [WID-1:0]         in_vld;
  logic [WID-1:0]         in_lst;
  logic [WID*DAT_WID-1:0] in_dat;
  logic [WID-1:0]         in_rdy;
  logic                   out_vld;
  logic                   out_lst;
  logic [DAT_WID-1:0]     out_dat;
  logic [SRC_WID-1:0]     out_src;
  logic                   out_rdy;
  logic                   busy;

  arb_rr_pkt_mux #(.WID(WID), .DAT_WID(DAT_WID)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .in_lst  (in_lst),
    .in_dat  (in_dat),
    .in_rdy  (in_rdy),
    .out_vld (out_vld),
    .out_lst (out_lst),
    .out_dat (out_dat),
    .out_src (out_src),
    .out_rdy (out_rdy),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: expected output register plus packet ownership and next search start.
  logic               m_vld, m_lst;
  logic [DAT_WID-1:0] m_dat;
  int                 m_src, m_owner, m_start;
  bit                 m_lock;

  // Source drivers: the beat currently offered and beats left in the packet.
  bit                 s_have[WID];
  bit                 s_lst[WID];
  int                 s_left[WID];
  logic [DAT_WID-1:0] s_dat[WID];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vld = 1'b0; m_lst = 1'b0; m_dat = '0; m_src = 0;
    m_lock = 1'b0; m_owner = 0; m_start = 0;
    exp_q.delete();
    for (int i = 0; i < WID; i++) begin
      s_have[i] = 1'b0; s_lst[i] = 1'b0; s_left[i] = 0; s_dat[i] = '0;
    end
    in_vld = '0; in_lst = '0; in_dat = '0; out_rdy = 1'b0;
  endtask

  // mode 0: every source streams single-beat packets carrying its index, out_rdy=1
  // mode 1: random offers, packet lengths 1..4, random backpressure
  // mode 2: only source 3, 4-beat packets, out_rdy=1
  task automatic drive(input int mode);
    for (int i = 0; i < WID; i++) begin
      if (!s_have[i] && (mode == 0 || (mode == 1 && $urandom_range(0, 2) != 0) ||
                         (mode == 2 && i == 3))) begin
        if (s_left[i] == 0) s_left[i] = (mode == 0) ? 1 : (mode == 2) ? 4 : $urandom_range(1, 4);
        s_have[i] = 1'b1;
        s_dat[i]  = (mode == 0) ? DAT_WID'(i) : $urandom();
        s_lst[i]  = (s_left[i] == 1);
      end
      in_vld[i] = s_have[i];
      in_lst[i] = s_lst[i];
      in_dat[i*DAT_WID +: DAT_WID] = s_dat[i];
    end
    out_rdy = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic step(input int mode);
    int g;
    bit found, free;
    logic [WID-1:0] exp_rdy;
    @(negedge clk);
    drive(mode);
    #1;
    chk("out_vld", out_vld, m_vld);
    chk("out_lst", out_lst, m_lst);
    chk("out_dat", out_dat, m_dat);
    chk("out_src", out_src, m_src);
    chk("busy", busy, m_lock);
    free  = !m_vld || out_rdy;
    found = 1'b0;
    g     = 0;
    if (m_lock) begin
      found = 1'b1;
      g     = m_owner;
    end else begin
      for (int k = 0; k < WID; k++) begin
        int c;
        c = (m_start + k) % WID;
        if (!found && in_vld[c]) begin
          found = 1'b1;
          g     = c;
        end
      end
    end
    exp_rdy = (found && free) ? (WID'(1) << g) : '0;
    chk("in_rdy", in_rdy, exp_rdy);
    if (out_vld && out_rdy) begin
      chk("sb_depth", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("sb_beat", {out_src, out_lst, out_dat}, exp_q.pop_front());
    end
    if (found && free && in_vld[g]) begin
      exp_q.push_back({SRC_WID'(g), s_lst[g], s_dat[g]});
      m_vld = 1'b1; m_lst = s_lst[g]; m_dat = s_dat[g]; m_src = g;
      if (s_lst[g]) begin
        m_lock  = 1'b0;
        m_start = (g + 1) % WID;
      end else begin
        m_lock  = 1'b1;
        m_owner = g;
      end
      s_have[g] = 1'b0;
      s_left[g]--;
    end else if (free) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_vld"}, out_vld, 0);
    chk({tag, "_out_lst"}, out_lst, 0);
    chk({tag, "_out_dat"}, out_dat, 0);
    chk({tag, "_out_src"}, out_src, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_zero_outputs("reset");
    chk("reset_in_rdy", in_rdy, 0);

    repeat (40) step(0);
    repeat (1500) step(1);

    // Abandon a 4-beat packet from source 3 right after its first beat.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    @(posedge clk);
    #2;
    chk("mid_pkt_busy", busy, m_lock);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    model_reset();
    #1;
    rst_n = 1'b1;

    repeat (40) step(0);
    repeat (400) step(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/arb_rr_pkt_mux.md
# arb_rr_pkt_mux

Packet-aware round-robin multiplexer: merges WID valid/ready streams onto one output stream. Arbitration is round-robin with lsb highest priority on wrap. A grant is held for the whole packet, from first beat to `in_lst` beat. Sits in front of any shared single-port datapath (bus master port, FIFO write side, serializer) that must not see interleaved packets. Output is a single registered stage.

## Interface

**Parameters**
- `WID`, 4, number of requesters (≥2)
- `DAT_WID`, 32, data beat width in bits
- `SRC_WID`, `$clog2(WID)`, width of source index (localparam)

**Ports**
- `clk` input 1: clock
- `rst_n` input 1: reset, asynchronous, active-low
- `in_vld` input WID: per-source beat valid
- `in_lst` input WID: per-source last-beat-of-packet flag
- `in_dat` input WID*DAT_WID: per-source data; source i at bits [i*DAT_WID +: DAT_WID]
- `in_rdy` output WID: per-source ready; combinational; at most one bit set
- `out_vld` output 1: output beat valid (registered)
- `out_lst` output 1: output last flag (registered)
- `out_dat` output DAT_WID: output data (registered)
- `out_src` output SRC_WID: index of the source of the current output beat (registered)
- `out_rdy` input 1: downstream ready
- `busy` output 1: high while a packet is locked (mid-packet)

## Operation

- **State:** `lock` (1b), `owner` (SRC_WID), `mask` (WID), output register {`out_vld`, `out_lst`, `out_dat`, `out_src`}.
- **Reset values:**
  - `lock`=0, `owner`=0, `mask`=all ones
  - `out_vld`=0, `out_lst`=0, `out_dat`=0, `out_src`=0, `busy`=0
- **Load enable:** `ld = !out_vld || out_rdy`.
- **IDLE (`lock`=0), arbitration:**
  - `mreq = in_vld & mask`
  - `sel` = lowest set bit of `mreq` if `mreq`≠0, else lowest set bit of `in_vld`.
  - `in_rdy[sel] = ld` when any `in_vld` is set; all other bits 0.
- **LOCKED (`lock`=1):**
  - `in_rdy[owner] = ld`; all other bits 0.
  - No arbitration.
  - Other sources' valids are ignored regardless of `mask`.
- **Beat transfer:** `in_vld[g] && in_rdy[g]`, where g is `sel` in IDLE or `owner` in LOCKED.
  - Output register loads `in_dat[g]`, `in_lst[g]`, with `out_src`=g and `out_vld`=1.
- **Transfer with `in_lst[g]`=0:** `lock`←1, `owner`←g.
- **Transfer with `in_lst[g]`=1:**
  - `lock`←0.
  - `mask`←bits strictly above g set, i.e. ~((2<<g)-1) truncated to WID.
  - g = WID-1 gives `mask`=0, which falls back to the unmasked search, so source 0 has priority next.
- **Single-beat packet:** a beat with `in_lst`=1 accepted in IDLE never locks; the mask still updates.
- **No transfer while `ld`=1:** `out_vld`←0, other output fields hold.
- **`ld`=0:** all output fields hold.
- **`busy` = `lock`.**
- **Owner drops `in_vld` mid-packet:**
  - Lock is held and bubbles appear on the output.
  - Other sources stay blocked indefinitely. No timeout.
- **Reset mid-packet:** all state returns to reset values immediately (async). The partial packet is abandoned and the next arbitration starts from lsb priority.

## Timing

- Latency: beat accepted in cycle N appears on `out_*` in cycle N+1.
- Throughput: 1 beat/cycle with `out_rdy`=1. No bubble between back-to-back packets, including packets from different sources.
- `in_rdy` depends combinationally on `out_rdy`, `out_vld`, `in_vld`, `lock`, `mask`. No combinational path from `in_dat`.
- Mask and lock updates take effect the cycle after the accepting edge.
- While `out_vld`=1 && `out_rdy`=0:
  - `out_*` are stable.
  - All `in_rdy` are 0.
- `out_vld` never deasserts without an `out_rdy` handshake.
- Sources must hold `in_vld`/`in_dat`/`in_lst` stable until accepted. The block does not check this.

## Test plan

- **Reset/idle:** assert `rst_n`=0, then release with `in_vld`=4'b0000 → all `out_*`=0, `busy`=0, `in_rdy`=0. Then drive `in_vld`=4'b1111 → `in_rdy`=4'b0001.
- **Fair rotation:** WID=4, all sources send continuous single-beat packets (`in_lst`=1, `in_dat`=source index), `out_rdy`=1 → `out_src` sequence 0,1,2,3,0,1…, one beat per cycle, `busy` always 0.
- **Packet lock:** source 1 sends a 3-beat packet (A,B,C) while sources 0 and 2 request single beats → output sequence is 1A,1B,1C,2,0. `busy`=1 during the cycles after A and B are accepted. `in_rdy[0]` and `in_rdy[2]` stay 0 throughout.
- **Backpressure:** with `out_vld`=1, drive `out_rdy`=0 for 3 cycles → `out_dat`/`out_src`/`out_lst` are unchanged and `in_rdy`=0. On release, the next beat follows in the next cycle with no loss or duplication.
- **Owner stall:** source 2 mid-packet drops `in_vld` for 2 cycles while source 0 is valid → `out_vld`=0 for 2 cycles, `in_rdy[0]`=0, and source 2's remaining beats follow contiguously.
- **Reset mid-packet:** assert `rst_n` low after beat 1 of a 4-beat packet from source 3 → outputs are immediately zero, `busy`=0. After release with all sources valid → `in_rdy`=4'b0001.
